// File: rtl/snake_pkg.sv
// Shared definitions for the snake display raster and game-step timing.
// Contents: 640x480@60 VGA timing (porches, sync widths, derived totals and
// sync windows), sync polarity, counter widths and the speed_sel -> frames
// per game step lookup.
package snake_pkg;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned FCNT_W   = 3;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam logic SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        SPD_8F = 2'd0,
        SPD_4F = 2'd1,
        SPD_2F = 2'd2,
        SPD_1F = 2'd3
    } speed_e;

    // Returns N-1, where N is the number of frames per game step. Using N-1
    // keeps the value inside the 3-bit frame counter range (N=8 -> 7).
    function automatic logic [FCNT_W-1:0] step_last(input logic [1:0] sel);
        logic [FCNT_W-1:0] last;
        case (speed_e'(sel))
            SPD_8F:  last = 3'd7;
            SPD_4F:  last = 3'd3;
            SPD_2F:  last = 3'd1;
            default: last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/vga_scan_gen_step_divider.sv
// step_divider: counts frames at each vertical-blank point and emits the
// one-clock game-step pulse (updateclock) every N frames.
// Ports:
//   clk_d, rst_n  pixel clock, async active-low reset
//   run           0 holds the pulse off and clears the frame counter
//   speed_sel     frames per step: 0->8, 1->4, 2->2, 3->1
//   blank_pt      strobe, high on the clock whose registered outputs will
//                 present (0, V_ACTIVE)
//   updateclock   registered step pulse, aligned with that presented position
module step_divider
    import snake_pkg::*;
(
    input  logic       clk_d,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] speed_sel,
    input  logic       blank_pt,
    output logic       updateclock
);

    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              updateclock_q, updateclock_d;

    // speed_sel is looked at only here, on the blank point, so a change
    // takes effect at the next blank point. Comparing with >= means a count
    // already past the new N-1 fires immediately instead of being skipped.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        updateclock_d = 1'b0;
        if (!run) begin
            frame_cnt_d = '0;
        end else if (blank_pt) begin
            if (frame_cnt_q >= step_last(speed_sel)) begin
                updateclock_d = 1'b1;
                frame_cnt_d   = '0;
            end else if (frame_cnt_q != '1) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            updateclock_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            updateclock_q <= updateclock_d;
        end
    end

    assign updateclock = updateclock_q;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster-scan source for the snake display. Produces the pixel
// position, sync pulses, video_on, a frame_start pulse and the game-step
// pulse (updateclock) issued during vertical blanking.
// Ports:
//   clk_d, rst_n        pixel clock (25 MHz), async active-low reset
//   run, speed_sel      game-step control, see step_divider
//   xCount, yCount      current column / line
//   hsync, vsync        sync outputs, active level = SYNC_POL
//   video_on            inside the visible 640x480 area
//   frame_start         one clock at (0,0)
//   updateclock         one clock at (0,V_ACTIVE) every N frames while run=1
// Timing parameters default to the package values and can be overridden
// (e.g. a reduced raster for quick simulation).
module vga_scan_gen #(
    parameter int unsigned H_ACTIVE = snake_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = snake_pkg::H_FP,
    parameter int unsigned H_SYNC   = snake_pkg::H_SYNC,
    parameter int unsigned H_BP     = snake_pkg::H_BP,
    parameter int unsigned V_ACTIVE = snake_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = snake_pkg::V_FP,
    parameter int unsigned V_SYNC   = snake_pkg::V_SYNC,
    parameter int unsigned V_BP     = snake_pkg::V_BP,
    parameter logic        SYNC_POL = snake_pkg::SYNC_POL
) (
    input  logic                         clk_d,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic [1:0]                   speed_sel,
    output logic [snake_pkg::CNT_W-1:0]  xCount,
    output logic [snake_pkg::CNT_W-1:0]  yCount,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         video_on,
    output logic                         frame_start,
    output logic                         updateclock
);

    localparam int unsigned W = snake_pkg::CNT_W;

    localparam logic [W-1:0] H_LAST  = W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [W-1:0] V_LAST  = W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [W-1:0] H_ACT   = W'(H_ACTIVE);
    localparam logic [W-1:0] V_ACT   = W'(V_ACTIVE);
    localparam logic [W-1:0] HS_BEG  = W'(H_ACTIVE + H_FP);
    localparam logic [W-1:0] HS_FIN  = W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [W-1:0] VS_BEG  = W'(V_ACTIVE + V_FP);
    localparam logic [W-1:0] VS_FIN  = W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         hsync_q, hsync_d;
    logic         vsync_q, vsync_d;
    logic         video_on_q, video_on_d;
    logic         frame_start_q, frame_start_d;
    logic         blank_pt;

    // Flags are decoded from the next counter values so that, once
    // registered, they line up with the position presented on the same clock.
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
        hsync_d       = (x_d >= HS_BEG && x_d <= HS_FIN) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (y_d >= VS_BEG && y_d <= VS_FIN) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
        frame_start_d = (x_d == '0) && (y_d == '0);
        blank_pt      = (x_d == '0) && (y_d == V_ACT);
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    step_divider u_step_div (
        .clk_d       (clk_d),
        .rst_n       (rst_n),
        .run         (run),
        .speed_sel   (speed_sel),
        .blank_pt    (blank_pt),
        .updateclock (updateclock)
    );

    assign xCount      = x_q;
    assign yCount      = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a reduced raster: 16+2+3+3 = 24 clocks per line,
// 6+2+2+2 = 12 lines per frame (288 clocks), active-low syncs.
// hsync window x in [18,20], vsync window y in [8,9], blank point (0,6),
// which sits 144 clocks after a frame start.
module tb_vga_scan_gen;

    localparam int HT     = 24;
    localparam int VT     = 12;
    localparam int HA     = 16;
    localparam int VA     = 6;
    localparam int FRAME  = HT * VT;
    localparam int BP_OFS = VA * HT;

    logic       clk_d = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic [9:0] xCount, yCount;
    logic       hsync, vsync, video_on, frame_start, updateclock;

    int checks   = 0;
    int failures = 0;
    int ex, ey, cyc;
    int fs_cnt, fs_gap, fs_last;
    int upd_cnt, upd_gap, upd_first, upd_last;
    int hs_cnt, vs_cnt, von_cnt;

    vga_scan_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0)
    ) dut (
        .clk_d       (clk_d),
        .rst_n       (rst_n),
        .run         (run),
        .speed_sel   (speed_sel),
        .xCount      (xCount),
        .yCount      (yCount),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .frame_start (frame_start),
        .updateclock (updateclock)
    );

    always #5 clk_d = ~clk_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr_stats();
        cyc = 0;
        fs_cnt = 0; fs_gap = 0; fs_last = 0;
        upd_cnt = 0; upd_gap = 0; upd_first = 0; upd_last = 0;
        hs_cnt = 0; vs_cnt = 0; von_cnt = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},   32'(xCount), 0);
        chk({tag, "_y"},   32'(yCount), 0);
        chk({tag, "_hs"},  32'(hsync), 1);
        chk({tag, "_vs"},  32'(vsync), 1);
        chk({tag, "_von"}, 32'(video_on), 0);
        chk({tag, "_fs"},  32'(frame_start), 0);
        chk({tag, "_upd"}, 32'(updateclock), 0);
        chk({tag, "_fcnt"}, 32'(dut.u_step_div.frame_cnt_q), 0);
    endtask

    // Advance n clocks; after each edge compare the position and flags with
    // the expected raster position and gather pulse statistics.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_d);
            cyc++;
            if (ex == HT - 1) begin
                ex = 0;
                ey = (ey == VT - 1) ? 0 : ey + 1;
            end else begin
                ex++;
            end
            @(negedge clk_d);
            chk("x",        32'(xCount), ex);
            chk("y",        32'(yCount), ey);
            chk("hsync",    32'(hsync), (ex >= 18 && ex <= 20) ? 0 : 1);
            chk("vsync",    32'(vsync), (ey >= 8 && ey <= 9) ? 0 : 1);
            chk("video_on", 32'(video_on), (ex < HA && ey < VA) ? 1 : 0);
            chk("frame_start", 32'(frame_start), (ex == 0 && ey == 0) ? 1 : 0);
            if (frame_start) begin
                if (fs_cnt > 0) fs_gap = cyc - fs_last;
                fs_last = cyc;
                fs_cnt++;
            end
            if (!hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
            if (video_on) von_cnt++;
            if (updateclock) begin
                chk("upd_pos_x", 32'(xCount), 0);
                chk("upd_pos_y", 32'(yCount), VA);
                chk("upd_video", 32'(video_on), 0);
                if (upd_cnt == 0) upd_first = cyc;
                else upd_gap = cyc - upd_last;
                upd_last = cyc;
                upd_cnt++;
            end
        end
    endtask

    initial begin
        ex = 0; ey = 0;
        clr_stats();

        // Reset state
        repeat (3) @(negedge clk_d);
        chk_reset_vals("rst");

        // Release, two frames of raster with run=0
        rst_n = 1'b1;
        run_cycles(1);
        chk("first_x", 32'(xCount), 1);
        chk("first_y", 32'(yCount), 0);
        chk("first_von", 32'(video_on), 1);
        run_cycles(2 * FRAME - 1);
        chk("fs_count", fs_cnt, 2);
        chk("fs_period", fs_gap, FRAME);
        chk("hs_clocks", hs_cnt, 2 * VT * 3);
        chk("vs_clocks", vs_cnt, 2 * 2 * HT);
        chk("von_clocks", von_cnt, 2 * HA * VA);
        chk("upd_idle", upd_cnt, 0);

        // run=1, 4 frames per step
        run = 1'b1; speed_sel = 2'd1;
        clr_stats();
        run_cycles(8 * FRAME);
        chk("spd4_count", upd_cnt, 2);
        chk("spd4_first", upd_first, BP_OFS + 3 * FRAME);
        chk("spd4_gap", upd_gap, 4 * FRAME);

        // every frame
        speed_sel = 2'd3;
        clr_stats();
        run_cycles(3 * FRAME);
        chk("spd1_count", upd_cnt, 3);
        chk("spd1_first", upd_first, BP_OFS);
        chk("spd1_gap", upd_gap, FRAME);

        // count up to 5 at 8 frames per step, then switch to 1 frame per step
        speed_sel = 2'd0;
        clr_stats();
        run_cycles(5 * FRAME);
        chk("spd8_none", upd_cnt, 0);
        chk("fcnt_5", 32'(dut.u_step_div.frame_cnt_q), 5);
        speed_sel = 2'd3;
        clr_stats();
        run_cycles(3 * FRAME);
        chk("switch_count", upd_cnt, 3);
        chk("switch_first", upd_first, BP_OFS);
        chk("switch_gap", upd_gap, FRAME);

        // run=0 for three frames
        run = 1'b0;
        clr_stats();
        run_cycles(3 * FRAME);
        chk("stop_none", upd_cnt, 0);
        chk("stop_fcnt", 32'(dut.u_step_div.frame_cnt_q), 0);
        chk("stop_fs", fs_cnt, 3);

        // run 0->1 at 2 frames per step: first step on the second blank point
        run = 1'b1; speed_sel = 2'd2;
        clr_stats();
        run_cycles(2 * FRAME);
        chk("restart_count", upd_cnt, 1);
        chk("restart_first", upd_first, BP_OFS + FRAME);

        // Reset mid-line at (10,3)
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (ex == 10 && ey == 3) break;
            run_cycles(1);
        end
        chk("mid_pos_x", 32'(xCount), 10);
        chk("mid_pos_y", 32'(yCount), 3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(negedge clk_d);
        chk_reset_vals("rst_hold");

        rst_n = 1'b1;
        ex = 0; ey = 0;
        clr_stats();
        run_cycles(1);
        chk("rel_x", 32'(xCount), 1);
        chk("rel_y", 32'(yCount), 0);
        chk("rel_von", 32'(video_on), 1);
        run_cycles(2 * FRAME - 1);
        chk("rel_fs_count", fs_cnt, 2);
        chk("rel_fs_period", fs_gap, FRAME);
        chk("rel_upd_count", upd_cnt, 1);
        chk("rel_upd_first", upd_first, BP_OFS + FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
